// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: data, MDU, eret hazards and exception flush.
// Latency: enables/bubbles are combinational (zero cycles); state is MDU timer + stall counter.
// Backpressure: a stall freezes PC and IF/ID and injects a bubble into ID/EX; an exception overrides it.
// Optional stall counter enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [2:0]  tuse_rs_D,
  input  logic [2:0]  tuse_rt_D,
  input  logic        mdu_use_D,
  input  logic        eret_D,
  input  logic [4:0]  regA3_E,
  input  logic [4:0]  regA3_M,
  input  logic [2:0]  tnew_E,
  input  logic [2:0]  tnew_M,
  input  logic        start_E,
  input  logic        is_div_E,
  input  logic        cp0write_E,
  input  logic        cp0write_M,
  input  logic [4:0]  rd_E,
  input  logic [4:0]  rd_M,
  input  logic        intExcReq,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_nop,
  output logic        id_ex_nop,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES);
  localparam logic [4:0] EPC_IDX = 5'd14;

  logic [4:0] cnt;
  logic       hz_rs;
  logic       hz_rt;
  logic       hz_mdu;
  logic       hz_eret;
  logic       stall;

  assign mdu_busy = (cnt != 5'd0);

  // Hazard detection: a producer whose result arrives later than the consumer needs it stalls decode.
  // Tuse=7 never loses the comparison because Tnew is at most 7.
  always_comb begin
    hz_rs   = (rs_D != 5'd0) &&
              (((rs_D == regA3_E) && (tnew_E > tuse_rs_D)) ||
               ((rs_D == regA3_M) && (tnew_M > tuse_rs_D)));
    hz_rt   = (rt_D != 5'd0) &&
              (((rt_D == regA3_E) && (tnew_E > tuse_rt_D)) ||
               ((rt_D == regA3_M) && (tnew_M > tuse_rt_D)));
    hz_mdu  = mdu_use_D && (mdu_busy || start_E);
    hz_eret = eret_D && ((cp0write_E && (rd_E == EPC_IDX)) ||
                         (cp0write_M && (rd_M == EPC_IDX)));
    stall   = hz_rs || hz_rt || hz_mdu || hz_eret;
  end

  // Stage enables: exception beats stall beats normal flow; registers flush themselves on exception.
  always_comb begin
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    id_ex_we  = 1'b1;
    ex_mem_we = 1'b1;
    mem_wb_we = 1'b1;
    if_id_nop = 1'b0;
    id_ex_nop = 1'b0;
    if (intExcReq) begin
      // all defaults hold
    end else if (stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_nop = 1'b1;
    end else begin
      // kill the instruction fetched behind eret
      if_id_nop = eret_D;
    end
  end

  // MDU busy timer: loads on an accepted start, otherwise counts down to zero.
  // An exception does not cancel a running operation, it only blocks a new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 5'd0;
    end else if (start_E && !intExcReq) begin
      cnt <= is_div_E ? DIV_LD : MULT_LD;
    end else if (cnt != 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Stall cycle counter: counts cycles actually lost to a stall, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && !intExcReq) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic.
// Reference model tracks the MDU as "last accepted start cycle + duration".
// Summary line reports passed/total comparisons.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, regA3_E, regA3_M, rd_E, rd_M;
  logic [2:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        mdu_use_D, eret_D, start_E, is_div_E, cp0write_E, cp0write_M, intExcReq;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_nop, id_ex_nop, mdu_busy;
  logic [31:0] stall_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_start = -1000;
  int          last_n = 0;
  logic [31:0] perf = 32'd0;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .mdu_use_D(mdu_use_D), .eret_D(eret_D),
    .regA3_E(regA3_E), .regA3_M(regA3_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .start_E(start_E), .is_div_E(is_div_E),
    .cp0write_E(cp0write_E), .cp0write_M(cp0write_M), .rd_E(rd_E), .rd_M(rd_M),
    .intExcReq(intExcReq),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_nop(if_id_nop), .id_ex_nop(id_ex_nop),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit model_busy();
    return (cyc > last_start) && (cyc <= last_start + last_n);
  endfunction

  // Expected {pc_we,if_id_we,id_ex_we,ex_mem_we,mem_wb_we,if_id_nop,id_ex_nop,mdu_busy}
  function automatic logic [7:0] exp_vec(output bit st);
    bit busy, h_rs, h_rt, h_mdu, h_eret;
    busy   = model_busy();
    h_rs   = (rs_D != 0) && ((rs_D == regA3_E && tnew_E > tuse_rs_D) ||
                             (rs_D == regA3_M && tnew_M > tuse_rs_D));
    h_rt   = (rt_D != 0) && ((rt_D == regA3_E && tnew_E > tuse_rt_D) ||
                             (rt_D == regA3_M && tnew_M > tuse_rt_D));
    h_mdu  = mdu_use_D && (busy || start_E);
    h_eret = eret_D && ((cp0write_E && rd_E == 14) || (cp0write_M && rd_M == 14));
    st     = h_rs || h_rt || h_mdu || h_eret;
    if (intExcReq)   return {5'b11111, 2'b00, busy};
    else if (st)     return {5'b00111, 2'b01, busy};
    else             return {5'b11111, eret_D, 1'b0, busy};
  endfunction

  // Called just after a negedge with inputs settled; compares, then advances one clock.
  task automatic step(input string tag);
    logic [7:0] e;
    bit st;
    #1;
    e = exp_vec(st);
    chk({tag, ":ctl"}, {24'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                        if_id_nop, id_ex_nop, mdu_busy}, {24'd0, e});
    chk({tag, ":cnt"}, stall_cnt, PERF_EN ? perf : 32'd0);
    @(posedge clk);
    if (reset) begin
      last_start = -1000; last_n = 0; perf = 32'd0;
    end else begin
      if (start_E && !intExcReq) begin
        last_start = cyc; last_n = is_div_E ? DIV_N : MULT_N;
      end
      if (st && !intExcReq) perf = perf + 32'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; tuse_rs_D = 3'd7; tuse_rt_D = 3'd7; mdu_use_D = 0; eret_D = 0;
    regA3_E = 0; regA3_M = 0; tnew_E = 0; tnew_M = 0; start_E = 0; is_div_E = 0;
    cp0write_E = 0; cp0write_M = 0; rd_E = 0; rd_M = 0; intExcReq = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    step("reset_hold");
    reset = 1'b0;
    step("idle");

    // load-use, then producer in MEM with Tnew equal to Tuse
    regA3_E = 1; tnew_E = 2; rs_D = 1; tuse_rs_D = 1;
    step("load_use");
    regA3_E = 0; tnew_E = 0; regA3_M = 1; tnew_M = 1;
    step("load_use_mem");
    clear_inputs();

    // $0 never stalls
    regA3_E = 0; tnew_E = 3; rs_D = 0; tuse_rs_D = 0;
    step("zero_reg");
    clear_inputs();

    // mult then div with a waiting mfhi
    for (int k = 0; k < 2; k++) begin
      mdu_use_D = 1; start_E = 1; is_div_E = (k == 1);
      step(k == 0 ? "mult_t0" : "div_t0");
      start_E = 0; is_div_E = 0;
      for (int i = 0; i < (k == 0 ? MULT_N : DIV_N) + 1; i++)
        step(k == 0 ? "mult_run" : "div_run");
      clear_inputs();
    end

    // exception overrides a data stall; start in the same cycle is not accepted
    regA3_E = 2; tnew_E = 2; rt_D = 2; tuse_rt_D = 0; intExcReq = 1;
    step("exc_stall");
    start_E = 1;
    step("exc_start");
    clear_inputs();
    step("exc_after");

    // eret vs EPC write
    eret_D = 1; cp0write_E = 1; rd_E = 14;
    step("eret_hz");
    cp0write_E = 0;
    step("eret_clear");
    cp0write_E = 1; rd_E = 12;
    step("eret_other");
    clear_inputs();

    // three data stalls
    regA3_M = 3; tnew_M = 2; rs_D = 3; tuse_rs_D = 0;
    repeat (3) step("three_stalls");
    clear_inputs();
    step("after_stalls");

    // async reset in the middle of a divide
    mdu_use_D = 1; start_E = 1; is_div_E = 1;
    step("div_for_rst");
    start_E = 0;
    step("div_mid");
    #2 reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, mdu_busy}, 32'd0);
    chk("async_cnt", stall_cnt, 32'd0);
    last_start = -1000; last_n = 0; perf = 32'd0;
    chk("async_stall_drop", {31'd0, pc_we}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    step("post_rst");

    // randomized traffic on a small register space so hazards are common
    for (int i = 0; i < 3000; i++) begin
      rs_D       = 5'($urandom_range(0, 3));
      rt_D       = 5'($urandom_range(0, 3));
      regA3_E    = 5'($urandom_range(0, 3));
      regA3_M    = 5'($urandom_range(0, 3));
      tuse_rs_D  = ($urandom_range(0, 4) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
      tuse_rt_D  = ($urandom_range(0, 4) == 0) ? 3'd7 : 3'($urandom_range(0, 2));
      tnew_E     = 3'($urandom_range(0, 3));
      tnew_M     = 3'($urandom_range(0, 2));
      mdu_use_D  = ($urandom_range(0, 2) == 0);
      start_E    = ($urandom_range(0, 9) == 0);
      is_div_E   = $urandom_range(0, 1) != 0;
      eret_D     = ($urandom_range(0, 5) == 0);
      cp0write_E = ($urandom_range(0, 3) == 0);
      cp0write_M = ($urandom_range(0, 3) == 0);
      rd_E       = ($urandom_range(0, 1) != 0) ? 5'd14 : 5'($urandom_range(0, 31));
      rd_M       = ($urandom_range(0, 1) != 0) ? 5'd14 : 5'($urandom_range(0, 31));
      intExcReq  = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
